// File: rtl/vend_pkg.sv
// vend_pkg: shared encodings for the multi-panel vending dispenser
// scheduler (FSM states, item codes, default panel count).
package vend_pkg;

  localparam int N_REQ_DEF = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [1:0] ITEM_NONE = 2'b00;
  localparam logic [1:0] ITEM1     = 2'b01;
  localparam logic [1:0] ITEM2     = 2'b10;
  localparam logic [1:0] ITEM3     = 2'b11;

endpackage

// File: rtl/vend_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts at ptr_i
// and wraps modulo N_REQ.
module rr_arbiter
  import vend_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [IW-1:0]    winner_o,
  output logic             any_valid_o
);

  localparam int W = IW + 1;

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [W-1:0]       off;
  logic [W-1:0]       sum;

  // Rotate so bit 0 is the panel at ptr, then take the lowest set bit.
  always_comb begin
    dbl = {valid_i, valid_i} >> ptr_i;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = W'(k);
    end
    sum = {1'b0, ptr_i} + off;
    if (sum >= W'(N_REQ)) sum = sum - W'(N_REQ);
    winner_o    = sum[IW-1:0];
    any_valid_o = |valid_i;
  end

endmodule

// File: rtl/vend_scheduler.sv
// vend_scheduler: arbitrates N_REQ panels onto one dispenser, runs the
// start/done handshake with a timeout, and counts completed vends.
module vend_scheduler
  import vend_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] req_item,
  output logic [N_REQ-1:0]   grant,
  output logic               disp_start,
  output logic [1:0]         disp_item,
  input  logic               disp_done,
  output logic               timeout_err,
  output logic [7:0]         served_cnt
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [1:0]       item_q, item_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic [7:0]       served_q, served_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0] valid;
  logic [IW-1:0]    win;
  logic             any;
  logic [1:0]       win_item;

  always_comb begin
    valid    = '0;
    win_item = ITEM_NONE;
    for (int i = 0; i < N_REQ; i++) begin
      valid[i] = req[i] && (req_item[2*i +: 2] != ITEM_NONE);
      if (win == IW'(i)) win_item = req_item[2*i +: 2];
    end
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .valid_i     (valid),
    .ptr_i       (ptr_q),
    .winner_o    (win),
    .any_valid_o (any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    grant_d  = grant_q;
    item_d   = item_q;
    start_d  = 1'b0;
    err_d    = err_q;
    served_d = served_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          win_d   = win;
          item_d  = win_item;
          grant_d = N_REQ'(1) << win;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        start_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the timeout cycle still counts as a vend.
        if (disp_done) begin
          served_d = served_q + 8'd1;
          grant_d  = '0;
          state_d  = S_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        ptr_d   = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      grant_q  <= '0;
      item_q   <= ITEM_NONE;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      served_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      grant_q  <= grant_d;
      item_q   <= item_d;
      start_q  <= start_d;
      err_q    <= err_d;
      served_q <= served_d;
      cnt_q    <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign disp_start  = start_q;
  assign disp_item   = item_q;
  assign timeout_err = err_q;
  assign served_cnt  = served_q;

endmodule

// File: doc/vend_scheduler.md
VEND_SCHEDULER -- requirements
Module: vend_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of customer panels sharing one dispenser.
REQ-002 Parameter TIMEOUT, default 200: maximum cycles to wait for disp_done after disp_start.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  N_REQ  per-panel purchase request, level, held by the panel until its grant.
REQ-006 req_item  input  2*N_REQ  item code per panel, bits [2i+1:2i]; 00 = none.
REQ-007 grant  output  N_REQ  one-hot owner of the dispenser, registered.
REQ-008 disp_start  output  1  one-cycle pulse commanding a vend.
REQ-009 disp_item  output  2  item code of the granted panel, stable while grant is nonzero.
REQ-010 disp_done  input  1  one-cycle pulse from the dispenser, vend complete.
REQ-011 timeout_err  output  1  sticky flag, dispenser failed to answer within TIMEOUT.
REQ-012 served_cnt  output  8  count of completed vends.

Function
REQ-013 States: IDLE, GRANT, START, WAIT_DONE and RELEASE, encoded in 3 bits.
REQ-014 Valid request: req[i]=1 and req_item[i] not equal to 00; invalid requests are never granted.
REQ-015 IDLE: with any valid request, latch the round-robin winner and its item, then go to GRANT; otherwise stay.
REQ-016 Round-robin: search starts at index ptr and wraps modulo N_REQ; ptr resets to 0 and becomes winner+1 (mod N_REQ) in RELEASE.
REQ-017 GRANT: assert grant[winner], drive disp_item, go to START (grant appears 1 cycle after the request is sampled in IDLE).
REQ-018 START: disp_start=1 for exactly this cycle, clear the timeout counter, go to WAIT_DONE.
REQ-019 WAIT_DONE: on disp_done, served_cnt is incremented with wrap 255->0, then go to RELEASE.
REQ-020 WAIT_DONE: the timeout counter increments each cycle without disp_done; on reaching TIMEOUT, set timeout_err and go to RELEASE.
REQ-021 disp_done and timeout in the same cycle: disp_done wins, served_cnt increments, timeout_err unchanged.
REQ-022 disp_done outside WAIT_DONE is ignored.
REQ-023 The owner dropping req after GRANT does not abort; the vend completes or times out.
REQ-024 req_item changes after the winner is latched are ignored; disp_item holds the latched code.
REQ-025 RELEASE: deassert grant, update ptr, go to IDLE; minimum spacing between successive disp_start pulses is 5 cycles.
REQ-026 timeout_err clears only on reset.
REQ-027 At most one grant bit is ever set; grant is zero in IDLE and RELEASE.

Reset
REQ-028 rst_n=0 at a clock edge forces IDLE, grant=0, disp_start=0, disp_item=00, timeout_err=0, served_cnt=0, ptr=0 and timeout counter=0.
REQ-029 Reset asserted mid-vend (any state) abandons the transaction with no served_cnt update.
REQ-030 Release from reset resumes with a fresh arbitration from ptr=0.

Structure
REQ-031 Package vend_pkg holds the state encoding, item code constants (NONE=00, ITEM1=01, ITEM2=10, ITEM3=11) and default N_REQ.
REQ-032 Round-robin selection is sub-module rr_arbiter: combinational, with inputs valid vector and ptr and outputs winner index and any_valid.
REQ-033 The FSM, counters and output registers live in vend_scheduler; outputs are registered, with no combinational input-to-output path.

Verification
REQ-034 Single request: req=0001 with item 01 and disp_done 3 cycles after disp_start -> grant=0001, disp_item=01, one disp_start pulse, served_cnt=1, grant=0 in RELEASE.
REQ-035 Fairness: req=1111 held with all items valid and immediate disp_done -> grants in order 0001, 0010, 0100, 1000, 0001.
REQ-036 Timeout: disp_done never arrives, TIMEOUT=200 -> timeout_err=1 exactly 200 cycles after WAIT_DONE entry, served_cnt unchanged, next request still served.
REQ-037 Invalid item: req=0011 with panel 0 item 00 and panel 1 item 10 -> only grant=0010, disp_item=10.
REQ-038 Simultaneous done/timeout: disp_done pulsed on the TIMEOUT cycle -> served_cnt increments, timeout_err stays 0.
REQ-039 Reset in WAIT_DONE: rst_n=0 for 1 cycle -> all outputs zero the next cycle, served_cnt=0, a later request with ptr=0 grants the lowest valid index.
